// File: rtl/if_v_4_demod.sv
// if_v_4_demod: correlating bit demodulator; sums sample*reference over SEG_LEN
// accepted samples, then decides the bit from the sign of the correlation.
module if_v_4_demod #(
   parameter int DATA_W  = 32,
   parameter int SEG_LEN = 16,
   parameter int ACC_W   = 2*DATA_W+8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sync_clear,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic [DATA_W-1:0] sample,
   output logic [7:0]        ref_idx,
   input  logic [DATA_W-1:0] array_ref_wire_4,
   output logic [DATA_W-1:0] bit_out,
   output logic [ACC_W-1:0]  corr_out,
   output logic              bit_valid,
   input  logic              bit_ready
);
   typedef enum logic {ACCUM, HOLD} state_t;
   state_t state, state_d;
   logic [ACC_W-1:0] acc, acc_d, corr_d, sum;
   logic signed [2*DATA_W-1:0] prod;
   logic [7:0] cnt, cnt_d;
   logic [DATA_W-1:0] bit_d;
   logic valid_d;
   assign prod = (2*DATA_W)'($signed(sample)) * (2*DATA_W)'($signed(array_ref_wire_4));
   assign sum = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign sample_ready = state == ACCUM;
   assign ref_idx = cnt;
   always_comb begin
      state_d = state;
      acc_d = acc;
      cnt_d = cnt;
      corr_d = corr_out;
      bit_d = bit_out;
      valid_d = bit_valid;
      if (sync_clear) begin
         state_d = ACCUM;
         acc_d = '0;
         cnt_d = '0;
         valid_d = 1'b0;
      end else if (state == HOLD) begin
         state_d = bit_ready ? ACCUM : HOLD;
         valid_d = !bit_ready;
      end else if (sample_valid) begin
         acc_d = cnt == 8'(SEG_LEN-1) ? '0 : sum;
         cnt_d = cnt == 8'(SEG_LEN-1) ? '0 : cnt + 8'd1;
         if (cnt == 8'(SEG_LEN-1)) begin
            state_d = HOLD;
            corr_d = sum;
            bit_d = {{(DATA_W-1){1'b0}}, sum[ACC_W-1]};
            valid_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ACCUM;
         acc <= '0;
         cnt <= '0;
         corr_out <= '0;
         bit_out <= '0;
         bit_valid <= 1'b0;
      end else begin
         state <= state_d;
         acc <= acc_d;
         cnt <= cnt_d;
         corr_out <= corr_d;
         bit_out <= bit_d;
         bit_valid <= valid_d;
      end
   end
endmodule

// File: doc/if_v_4_demod.md
IF_V_4_DEMOD -- requirements
Module: if_v_4_demod

Interface
REQ-001 Parameter: DATA_W, default 32, width of sample, reference and bit words.
REQ-002 Parameter: SEG_LEN, default 16, samples per bit segment; legal range 2..256.
REQ-003 Parameter: ACC_W, default 2*DATA_W+8, width of the signed correlation accumulator.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 Port: sync_clear  in  1  synchronous segment realignment; restarts the current segment.
REQ-007 Port: sample_valid  in  1  sample is valid this cycle.
REQ-008 Port: sample_ready  out  1  block accepts a sample this cycle.
REQ-009 Port: sample  in  DATA_W  received sample, two's-complement signed.
REQ-010 Port: ref_idx  out  8  index of the bit-zero reference sample for the next accepted sample.
REQ-011 Port: array_ref_wire_4  in  DATA_W  signed bit-zero reference sample at ref_idx, combinationally supplied.
REQ-012 Port: bit_out  out  DATA_W  decided bit; value 0 or 1 only.
REQ-013 Port: corr_out  out  ACC_W  signed final correlation for the segment.
REQ-014 Port: bit_valid  out  1  bit_out/corr_out valid.
REQ-015 Port: bit_ready  in  1  downstream accepts the result.

Function
REQ-016 The block SHALL implement FSM states ACCUM and HOLD.
REQ-017 In ACCUM, sample_ready SHALL be 1; in HOLD, sample_ready SHALL be 0.
REQ-018 A sample is accepted when sample_valid and sample_ready are both 1.
REQ-019 On accept, acc SHALL become acc + sign-extended (sample * array_ref_wire_4), with a full 2*DATA_W signed product.
REQ-020 On accept, cnt SHALL increment; ref_idx SHALL equal cnt at all times.
REQ-021 Accumulation SHALL wrap modulo 2^ACC_W without saturation; with the default ACC_W no overflow is possible.
REQ-022 On accept with cnt = SEG_LEN-1, the block SHALL perform all of the following at the next edge:
 - register corr_out = final acc value
 - register bit_out = 0 if final acc >= 0, else 1 (a correlation of exactly 0 decides 0)
 - set bit_valid = 1
 - clear acc and cnt to 0
 - enter HOLD
REQ-023 Latency: bit_valid SHALL rise exactly 1 cycle after the last sample of a segment is accepted.
REQ-024 In HOLD, bit_out, corr_out and bit_valid SHALL hold stable until bit_ready = 1.
REQ-025 When bit_valid and bit_ready are both 1, the block SHALL clear bit_valid at the next edge and return to ACCUM.
REQ-026 No sample SHALL be accepted in the handshake cycle, so there is a 1-cycle bubble between segments.
REQ-027 Samples with sample_valid = 0 SHALL leave acc and cnt unchanged; gaps of any length are allowed.
REQ-028 sync_clear = 1 SHALL clear acc and cnt at the next edge, discarding any sample offered in the same cycle.
REQ-029 sync_clear in HOLD SHALL also clear bit_valid and return to ACCUM, dropping the pending result.
REQ-030 sync_clear SHALL take priority over sample acceptance and over the output handshake.

Reset
REQ-031 While reset = 0, the block SHALL asynchronously force:
 - state = ACCUM
 - acc = 0, cnt = 0, ref_idx = 0
 - bit_out = 0, corr_out = 0, bit_valid = 0
REQ-032 After reset deasserts, sample_ready SHALL be 1 on the first clock.
REQ-033 Reset asserted mid-segment or in HOLD SHALL discard all partial and pending results.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
 - SEG_LEN=16, ref = +100 each sample, sample = +50 each sample, bit_ready = 1 -> corr_out = 80000, bit_out = 0, bit_valid for 1 cycle, 1 cycle after the 16th accept.
 - Same setup with sample = -50 -> corr_out = -80000, bit_out = 1.
 - Correlation exactly 0 (alternating +/-50 samples) -> bit_out = 0.
 - bit_ready held 0 for 5 cycles -> outputs stable, sample_ready = 0, no samples lost; next segment starts after the handshake.
 - sync_clear at sample 7 with sample_valid = 1 -> that sample dropped; the next bit uses the following 16 samples only.
 - reset pulsed low in HOLD and mid-segment -> all outputs 0 immediately (without waiting for a clock edge), ref_idx = 0, sample_ready = 1 after release.
 - Extremes: sample = ref = -2^31 for 16 samples -> corr_out = 2^66, no wrap, bit_out = 0.
